lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_align.sv | 59 +++++
 rtl/lsu_ctrl.sv | 136 +++++++++++++
 tb/tb_lsu_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  // True when the low address bits are not naturally aligned for the size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic r;
    r = ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
    return r;
  endfunction

  // Low address bits with the sub-size bits forced to zero.
  function automatic logic [1:0] aligned_lane(input logic [1:0] size, input logic [1:0] lo);
    logic [1:0] r;
    case (size)
      SZ_HALF: r = {lo[1], 1'b0};
      SZ_WORD: r = 2'b00;
      default: r = lo;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] load_word,
  input  logic [31:0] base_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = load_word[7:0];
    case (lane)
      2'd1:    byte_sel = load_word[15:8];
      2'd2:    byte_sel = load_word[23:16];
      2'd3:    byte_sel = load_word[31:24];
      default: byte_sel = load_word[7:0];
    endcase
    half_sel = lane[1] ? load_word[31:16] : load_word[15:0];
  end

  always_comb begin
    load_data = '0;
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      SZ_WORD: load_data = load_word;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    merge_word = base_word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    merge_word[7:0]   = store_data[7:0];
          2'd1:    merge_word[15:8]  = store_data[7:0];
          2'd2:    merge_word[23:16] = store_data[7:0];
          default: merge_word[31:24] = store_data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) merge_word[31:16] = store_data[15:0];
        else         merge_word[15:0]  = store_data[15:0];
      end
      SZ_WORD: merge_word = store_data;
      default: merge_word = base_word;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding access to a word memory.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses; otherwise the
// sub-size address bits are forced to zero and the access proceeds.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata
);

  localparam logic [29:0] WORDS_LIM = 30'(MEM_WORDS);

  state_e      state, state_next;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, cap_q;
  logic [31:0] rdata_q;
  logic        fault_q;
  logic        req_fault;
  logic [1:0]  req_lane;
  logic [31:0] load_data, merge_word;

  always_comb begin
    req_fault = 1'b0;
    req_lane  = req_addr[1:0];
    if (req_size == 2'd3)              req_fault = 1'b1;
    if (req_addr[31:2] >= WORDS_LIM)   req_fault = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (misaligned(req_size, req_addr[1:0])) req_fault = 1'b1;
`else
    req_lane = aligned_lane(req_size, req_addr[1:0]);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_fault)               state_next = RESP;
          else if (!req_we)            state_next = READ;
          else if (req_size == SZ_WORD) state_next = WRITE;
          else                         state_next = READ;
        end
      end
      READ:    state_next = we_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            addr_q  <= {req_addr[31:2], req_lane};
            wdata_q <= req_wdata;
            rdata_q <= '0;
            fault_q <= req_fault;
          end
        end
        READ: begin
          cap_q <= mem_rdata;
          if (!we_q) rdata_q <= load_data;
        end
        RESP: begin
          if (rsp_ready) begin
            rdata_q <= '0;
            fault_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  lsu_align u_align (
    .size        (size_q),
    .lane        (addr_q[1:0]),
    .is_unsigned (uns_q),
    .load_word   (mem_rdata),
    .base_word   (cap_q),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merge_word  (merge_word)
  );

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_rdata = rdata_q;
    rsp_fault = fault_q;
    mem_we    = (state == WRITE);
    mem_addr  = '0;
    mem_wdata = '0;
    if ((state == READ) || (state == WRITE)) mem_addr = {addr_q[31:2], 2'b00};
    if (state == WRITE) mem_wdata = merge_word;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl with a behavioural memory and reference model.
module tb_lsu_ctrl;

  localparam int unsigned MEM_WORDS = 64;
  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault, mem_we;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata, mem_addr, mem_rdata, mem_wdata;
  logic [29:0] maddr_w;

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  int unsigned cyc = 0;
  int unsigned wcount = 0;
  int n_checks = 0;
  int n_fail = 0;
  int unsigned ready_mode = 1;   // 0 hold low, 1 hold high, 2 random

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int unsigned lat;
    int unsigned writes;
    int unsigned acc_cyc;
    int unsigned acc_w;
    string       name;
  } exp_t;

  exp_t sb[$];
  bit   seen = 1'b0;

  lsu_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_fault    (rsp_fault),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata)
  );

  always #5 clk = ~clk;

  assign maddr_w = mem_addr[31:2];

  always_comb begin
    mem_rdata = '0;
    if (maddr_w < 30'(MEM_WORDS)) mem_rdata = mem[maddr_w[AW-1:0]];
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_we) begin
      wcount = wcount + 1;
      if (maddr_w < 30'(MEM_WORDS)) mem[maddr_w[AW-1:0]] = mem_wdata;
    end
  end

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0)      rsp_ready = 1'b0;
    else if (ready_mode == 1) rsp_ready = 1'b1;
    else                      rsp_ready = ($urandom_range(0, 3) != 0);
  end

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  // Reference: byte-addressed semantics on a word array, applied at issue time.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
    logic [31:0] a;
    int unsigned nb, idx, sh;
    logic [63:0] mask, w, v;
    e.rdata  = '0;
    e.fault  = 1'b0;
    e.writes = 0;
    a  = addr;
    nb = 1;
    if (size == 2'd3 || (addr / 4) >= MEM_WORDS) e.fault = 1'b1;
    else begin
      nb = 1 << size;
      if ((a % nb) != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
        e.fault = 1'b1;
`else
        a = a - (a % nb);
`endif
      end
    end
    if (e.fault)  e.lat = 1;
    else if (we)  e.lat = (nb == 4) ? 2 : 3;
    else          e.lat = 2;
    if (!e.fault) begin
      idx  = a / 4;
      sh   = 8 * (a % 4);
      mask = (64'd1 << (8 * nb)) - 64'd1;
      w    = {32'd0, ref_mem[idx]};
      if (we) begin
        v = (w & ~(mask << sh)) | (({32'd0, wdata} & mask) << sh);
        ref_mem[idx] = v[31:0];
        e.writes = 1;
      end else begin
        v = (w >> sh) & mask;
        if (!uns && v[8*nb-1]) v = v | ~mask;
        e.rdata = v[31:0];
      end
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input string name);
    exp_t e;
    int unsigned n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL %s_accept: req_ready stuck at %b, expected 1", name, req_ready);
      req_valid = 1'b0;
      return;
    end
    model(we, size, uns, addr, wdata, e);
    e.acc_cyc = cyc;
    e.acc_w   = wcount;
    e.name    = name;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      seen = 1'b0;
    end else begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid 1 with nothing outstanding, expected 0");
        end else begin
          if (!seen) begin
            chk({sb[0].name, "_latency"}, cyc - sb[0].acc_cyc, sb[0].lat);
            seen = 1'b1;
          end
          chk({sb[0].name, "_rdata"}, rsp_rdata, sb[0].rdata);
          chk({sb[0].name, "_fault"}, {31'd0, rsp_fault}, {31'd0, sb[0].fault});
          chk({sb[0].name, "_req_ready_busy"}, {31'd0, req_ready}, 32'd0);
          if (rsp_ready) begin
            chk({sb[0].name, "_writes"}, wcount - sb[0].acc_w, sb[0].writes);
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
      if (req_ready || rsp_valid) begin
        chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
        chk("idle_mem_addr", mem_addr, 32'd0);
      end
      chk("mem_addr_aligned", {30'd0, mem_addr[1:0]}, 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old;
    int unsigned n;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] ad;

    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_fault", {31'd0, rsp_fault}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    for (int unsigned i = 0; i < MEM_WORDS; i++) issue(1'b1, 2'd2, 1'b0, i * 4, $urandom, "preload");
    wait_idle();

    issue(1'b1, 2'd2, 1'b0, 32'h4, 32'h12A4_5678, "init_w1");
    issue(1'b0, 2'd0, 1'b0, 32'h6, 32'h0, "ld_b_s_6");
    issue(1'b0, 2'd0, 1'b0, 32'h5, 32'h0, "ld_b_s_5");
    issue(1'b0, 2'd0, 1'b1, 32'h6, 32'h0, "ld_b_u_6");
    issue(1'b0, 2'd1, 1'b0, 32'h6, 32'h0, "ld_h_s_6");
    issue(1'b1, 2'd2, 1'b0, 32'h4, 32'h1122_3344, "init_w1b");
    issue(1'b1, 2'd1, 1'b0, 32'h6, 32'h0000_BEEF, "st_h_6");
    wait_idle();
    chk("st_h_6_mem", mem[1], 32'hBEEF_3344);

    issue(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, "ld_w_2");
    issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, "st_w_oob");
    issue(1'b0, 2'd3, 1'b0, 32'h8, 32'h0, "ld_size3");
    issue(1'b1, 2'd0, 1'b0, 32'hFF, 32'h0000_00A5, "st_b_last");
    issue(1'b1, 2'd1, 1'b0, 32'h9, 32'h0000_1234, "st_h_odd");
    wait_idle();

    ready_mode = 0;
    @(negedge clk); @(negedge clk);
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, "ld_hold");
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    ready_mode = 1;
    wait_idle();

    old = mem[2];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h8; req_wdata = ~old;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rstw_mem_we_before", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rstw_mem_we_after", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rstw_mem_unchanged", mem[2], old);
    chk("rstw_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ad = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, MEM_WORDS * 4 - 1));
      issue(we, sz, 1'($urandom_range(0, 1)), ad, $urandom, "rand");
    end
    wait_idle();
    ready_mode = 1;

    for (int unsigned i = 0; i < MEM_WORDS; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
